qrd_unit: RTL and testbench



---
 rtl/qrd_unit_if.sv | 60 ++++++
 rtl/qrd_unit.sv | 231 +++++++++++++++++++++++
 tb/tb_qrd_unit.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qrd_unit_if.sv
// qrd_unit host bundle: write, read, op and config ports.
// master = host adapter, slave = qrd_unit.
interface qrd_unit_if;
  logic             io_write_req_valid;
  logic             io_write_req_bits;
  logic [4:0]       io_write_column;
  logic [5:0]       io_write_row;
  logic [7:0]       io_write_input_sign;
  logic [7:0][7:0]  io_write_input_exp;
  logic [7:0][22:0] io_write_input_frac;
  logic             io_read_req;
  logic [4:0]       io_read_column;
  logic [5:0]       io_read_row;
  logic             io_read_output_valid;
  logic [7:0]       io_read_output_bits_sign;
  logic [7:0][7:0]  io_read_output_bits_exp;
  logic [7:0][22:0] io_read_output_bits_frac;
  logic             io_op_valid;
  logic [1:0]       io_op_bits;
  logic             io_used_pus_valid;
  logic             io_used_pus_bits;
  logic             io_lengths_valid;
  logic [5:0]       io_lengths_bits_0;
  logic [5:0]       io_lengths_bits_1;
  logic             io_done;

  modport master (
    output io_write_req_valid, io_write_req_bits,
    output io_write_column, io_write_row,
    output io_write_input_sign, io_write_input_exp,
    output io_write_input_frac,
    output io_read_req, io_read_column, io_read_row,
    output io_op_valid, io_op_bits,
    output io_used_pus_valid, io_used_pus_bits,
    output io_lengths_valid,
    output io_lengths_bits_0, io_lengths_bits_1,
    input  io_read_output_valid,
    input  io_read_output_bits_sign,
    input  io_read_output_bits_exp,
    input  io_read_output_bits_frac,
    input  io_done
  );

  modport slave (
    input  io_write_req_valid, io_write_req_bits,
    input  io_write_column, io_write_row,
    input  io_write_input_sign, io_write_input_exp,
    input  io_write_input_frac,
    input  io_read_req, io_read_column, io_read_row,
    input  io_op_valid, io_op_bits,
    input  io_used_pus_valid, io_used_pus_bits,
    input  io_lengths_valid,
    input  io_lengths_bits_0, io_lengths_bits_1,
    output io_read_output_valid,
    output io_read_output_bits_sign,
    output io_read_output_bits_exp,
    output io_read_output_bits_frac,
    output io_done
  );
endinterface

// File: rtl/qrd_unit.sv
// QR working-set store with in-place sign/exponent PUs.
// QRD_UNIT_PU1_EN adds the second PU on column C+1.
module qrd_unit #(
  parameter int NUM_COLS = 32,
  parameter int NUM_ROWS = 64
) (
  input logic      clock,
  input logic      reset,
  qrd_unit_if.slave bus
);
  localparam int CW = $clog2(NUM_COLS);
  localparam int RW = $clog2(NUM_ROWS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN0 = 2'd1;
  localparam logic [1:0] S_RUN1 = 2'd2;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_NEG   = 2'd1;
  localparam logic [1:0] OP_ABS   = 2'd2;
  localparam logic [1:0] OP_HALVE = 2'd3;

  logic [7:0][31:0] r_mem [NUM_COLS][NUM_ROWS];

  logic [1:0]       r_state;
  logic [1:0]       r_op;
  logic [CW-1:0]    r_base;
  logic [RW-1:0]    r_row;
  logic [RW:0]      r_run_len0;
  logic [RW:0]      r_run_len1;
  logic             r_done;
  logic [RW-1:0]    r_len0;
  logic [RW-1:0]    r_len1;
  logic             r_rd_valid;
  logic [7:0][31:0] r_rd_data;

  logic             w_busy;
  logic             w_pu1;
  logic [RW:0]      w_l0;
  logic [RW:0]      w_l1;
  logic [CW-1:0]    w_col;
  logic [RW:0]      w_cur_len;
  logic             w_last;
  logic [7:0][31:0] w_cur_word;
  logic [7:0][31:0] w_new_word;
  logic [7:0][31:0] w_wr_word;

  function automatic logic [RW:0] f_clamp(
    input logic [RW-1:0] l
  );
    logic [RW:0] v;
    v = {1'b0, l};
    if (v > (RW+1)'(NUM_ROWS))
      v = (RW+1)'(NUM_ROWS);
    return v;
  endfunction

  function automatic logic [31:0] f_lane(
    input logic [31:0] w,
    input logic [1:0]  op
  );
    logic [31:0] v;
    v = w;
    case (op)
      OP_NEG: v[31] = ~w[31];
      OP_ABS: v[31] = 1'b0;
      OP_HALVE: begin
        if (w[30:23] == 8'd0 || w[30:23] == 8'hFF)
          v = w;
        else if (w[30:23] == 8'd1)
          v = {w[31], 31'd0};
        else
          v[30:23] = w[30:23] - 8'd1;
      end
      default: v = w;
    endcase
    return v;
  endfunction

`ifdef QRD_UNIT_PU1_EN
  logic r_used;

  // PU-count register, frozen while an op runs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_used <= 1'b0;
    else if (!w_busy && bus.io_used_pus_valid)
      r_used <= bus.io_used_pus_bits;
  end

  assign w_pu1 = r_used;
`else
  logic w_unused_pu1;
  assign w_pu1 = 1'b0;
  assign w_unused_pu1 = ^{bus.io_used_pus_valid,
                          bus.io_used_pus_bits,
                          r_len1};
`endif

  assign w_busy = (r_state != S_IDLE);

  // NOP runs zero rows; PU1 rows only when PU1 in use
  always_comb begin
    w_l0 = '0;
    w_l1 = '0;
    if (bus.io_op_bits != OP_NOP) begin
      w_l0 = f_clamp(r_len0);
      if (w_pu1)
        w_l1 = f_clamp(r_len1);
    end
  end

  assign w_col = (r_state == S_RUN1) ?
                 r_base + CW'(1) : r_base;
  assign w_cur_len = (r_state == S_RUN1) ?
                     r_run_len1 : r_run_len0;
  assign w_last = ((RW+1)'(r_row) + (RW+1)'(1))
                  == w_cur_len;
  assign w_cur_word = r_mem[w_col][r_row];

  // per-lane transform and host write-word packing
  always_comb begin
    w_new_word = '0;
    w_wr_word  = '0;
    for (int k = 0; k < 8; k++) begin
      w_new_word[k] = f_lane(w_cur_word[k], r_op);
      w_wr_word[k]  = {bus.io_write_input_sign[k],
                       bus.io_write_input_exp[k],
                       bus.io_write_input_frac[k]};
    end
  end

  // store: PU read-modify-write when busy, host write when idle
  always_ff @(posedge clock) begin
    if (reset && w_busy)
      r_mem[w_col][r_row] <= w_new_word;
    else if (reset && bus.io_write_req_valid)
      r_mem[bus.io_write_column][bus.io_write_row] <=
        bus.io_write_req_bits ? '0 : w_wr_word;
  end

  // length registers, frozen while an op runs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_len0 <= '0;
      r_len1 <= '0;
    end else if (!w_busy && bus.io_lengths_valid) begin
      r_len0 <= bus.io_lengths_bits_0;
      r_len1 <= bus.io_lengths_bits_1;
    end
  end

  // op sequencer: snapshot config at accept, walk rows
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_op       <= OP_NOP;
      r_base     <= '0;
      r_row      <= '0;
      r_run_len0 <= '0;
      r_run_len1 <= '0;
      r_done     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.io_op_valid) begin
            r_op       <= bus.io_op_bits;
            r_base     <= bus.io_read_column;
            r_row      <= '0;
            r_run_len0 <= w_l0;
            r_run_len1 <= w_l1;
            r_done     <= 1'b0;
            if (w_l0 != '0)
              r_state <= S_RUN0;
            else if (w_l1 != '0)
              r_state <= S_RUN1;
            else
              r_done <= 1'b1;
          end
        end
        S_RUN0: begin
          if (w_last) begin
            r_row <= '0;
            if (r_run_len1 != '0) begin
              r_state <= S_RUN1;
            end else begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end else begin
            r_row <= r_row + RW'(1);
          end
        end
        S_RUN1: begin
          if (w_last) begin
            r_row   <= '0;
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end else begin
            r_row <= r_row + RW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // read port: one-cycle latency, data held between reads
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= bus.io_read_req;
      if (bus.io_read_req)
        r_rd_data <= r_mem[bus.io_read_column][bus.io_read_row];
    end
  end

  // unpack read word onto lane fields
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      bus.io_read_output_bits_sign[k] = r_rd_data[k][31];
      bus.io_read_output_bits_exp[k]  = r_rd_data[k][30:23];
      bus.io_read_output_bits_frac[k] = r_rd_data[k][22:0];
    end
  end

  assign bus.io_read_output_valid = r_rd_valid;
  assign bus.io_done = r_done;
endmodule

// File: tb/tb_qrd_unit.sv
// Directed bench for qrd_unit: lane transform table
// plus hand sequences for multi-cycle corner cases.
module tb_qrd_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qrd_unit_if bus();

  qrd_unit #(
    .NUM_COLS(32),
    .NUM_ROWS(64)
  ) u_dut (
    .clock(clk),
    .reset(rst_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] din;
    logic [31:0] dout;
    int          cyc;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  function automatic logic [255:0] rep(input logic [31:0] x);
    return {8{x}};
  endfunction

  function automatic logic [255:0] out_word();
    logic [255:0] w;
    w = '0;
    for (int k = 0; k < 8; k++)
      w[k*32 +: 32] = {bus.io_read_output_bits_sign[k],
                       bus.io_read_output_bits_exp[k],
                       bus.io_read_output_bits_frac[k]};
    return w;
  endfunction

  task automatic drive_wr(input logic [4:0] col,
                          input logic [5:0] row,
                          input logic [255:0] w,
                          input logic zero);
    bus.io_write_req_valid = 1'b1;
    bus.io_write_req_bits  = zero;
    bus.io_write_column    = col;
    bus.io_write_row       = row;
    for (int k = 0; k < 8; k++) begin
      bus.io_write_input_sign[k] = w[k*32+31];
      bus.io_write_input_exp[k]  = w[k*32+23 +: 8];
      bus.io_write_input_frac[k] = w[k*32 +: 23];
    end
  endtask

  task automatic wr(input logic [4:0] col,
                    input logic [5:0] row,
                    input logic [255:0] w,
                    input logic zero);
    drive_wr(col, row, w, zero);
    tick();
    bus.io_write_req_valid = 1'b0;
  endtask

  task automatic rd(input logic [4:0] col,
                    input logic [5:0] row,
                    output logic [255:0] w,
                    output logic v);
    bus.io_read_req    = 1'b1;
    bus.io_read_column = col;
    bus.io_read_row    = row;
    tick();
    bus.io_read_req = 1'b0;
    v = bus.io_read_output_valid;
    w = out_word();
  endtask

  task automatic cfg(input logic used,
                     input logic [5:0] l0,
                     input logic [5:0] l1);
    bus.io_used_pus_valid = 1'b1;
    bus.io_used_pus_bits  = used;
    bus.io_lengths_valid  = 1'b1;
    bus.io_lengths_bits_0 = l0;
    bus.io_lengths_bits_1 = l1;
    tick();
    bus.io_used_pus_valid = 1'b0;
    bus.io_lengths_valid  = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!bus.io_done && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input logic [1:0] op,
                        input logic [4:0] col,
                        output int n);
    bus.io_op_valid    = 1'b1;
    bus.io_op_bits     = op;
    bus.io_read_column = col;
    tick();
    bus.io_op_valid = 1'b0;
    wait_done(n);
  endtask

  localparam logic [255:0] MIX_IN =
    {{6{32'h40800000}}, 32'h7F800000, 32'h00800000};
  localparam logic [255:0] MIX_OUT =
    {{6{32'h40000000}}, 32'h7F800000, 32'h00000000};

  initial begin
    logic [255:0] w;
    logic [255:0] w_a;
    logic v;
    int n;

    bus.io_write_req_valid = 1'b0;
    bus.io_write_req_bits  = 1'b0;
    bus.io_write_column    = '0;
    bus.io_write_row       = '0;
    bus.io_write_input_sign = '0;
    bus.io_write_input_exp  = '0;
    bus.io_write_input_frac = '0;
    bus.io_read_req        = 1'b0;
    bus.io_read_column     = '0;
    bus.io_read_row        = '0;
    bus.io_op_valid        = 1'b0;
    bus.io_op_bits         = '0;
    bus.io_used_pus_valid  = 1'b0;
    bus.io_used_pus_bits   = 1'b0;
    bus.io_lengths_valid   = 1'b0;
    bus.io_lengths_bits_0  = '0;
    bus.io_lengths_bits_1  = '0;

    vecs[0]  = '{2'd1, 32'h3F800000, 32'hBF800000, 1};
    vecs[1]  = '{2'd1, 32'hC0000000, 32'h40000000, 1};
    vecs[2]  = '{2'd2, 32'hC0400000, 32'h40400000, 1};
    vecs[3]  = '{2'd2, 32'h40400000, 32'h40400000, 1};
    vecs[4]  = '{2'd3, 32'h40800000, 32'h40000000, 1};
    vecs[5]  = '{2'd3, 32'h00800000, 32'h00000000, 1};
    vecs[6]  = '{2'd3, 32'h80FFFFFF, 32'h80000000, 1};
    vecs[7]  = '{2'd3, 32'h7F800000, 32'h7F800000, 1};
    vecs[8]  = '{2'd3, 32'h7FC00001, 32'h7FC00001, 1};
    vecs[9]  = '{2'd3, 32'h00000123, 32'h00000123, 1};
    vecs[10] = '{2'd0, 32'h12345678, 32'h12345678, 0};
    vecs[11] = '{2'd3, 32'hBF800000, 32'hBF000000, 1};

    // reset state
    repeat (3) tick();
    chk("rst_valid", 256'(bus.io_read_output_valid), 256'd0);
    chk("rst_data", out_word(), 256'd0);
    chk("rst_done", 256'(bus.io_done), 256'd0);
    rst_n = 1'b1;
    tick();

    // basic write / read
    wr(5'd3, 6'd5, rep(32'h3F800000), 1'b0);
    rd(5'd3, 6'd5, w, v);
    chk("rd_valid", 256'(v), 256'd1);
    chk("rd_data", w, rep(32'h3F800000));
    tick();
    chk("rd_valid_drop", 256'(bus.io_read_output_valid), 256'd0);
    chk("rd_hold", out_word(), rep(32'h3F800000));

    // lane transform table, one row at col 7
    for (int i = 0; i < 12; i++) begin
      wr(5'd7, 6'd0, rep(vecs[i].din), 1'b0);
      cfg(1'b0, 6'd1, 6'd0);
      run_op(vecs[i].op, 5'd7, n);
      chk($sformatf("tbl%0d_cyc", i), 256'(n),
          256'(vecs[i].cyc));
      rd(5'd7, 6'd0, w, v);
      chk($sformatf("tbl%0d_data", i), w, rep(vecs[i].dout));
    end

    // NEG over col 3 rows 0..3, row 4 untouched
    for (int r = 0; r < 5; r++)
      wr(5'd3, 6'(r), rep(32'h40000000), 1'b0);
    cfg(1'b0, 6'd4, 6'd0);
    run_op(2'd1, 5'd3, n);
    chk("neg_cyc", 256'(n), 256'd4);
    for (int r = 0; r < 4; r++) begin
      rd(5'd3, 6'(r), w, v);
      chk($sformatf("neg_row%0d", r), w, rep(32'hC0000000));
    end
    rd(5'd3, 6'd4, w, v);
    chk("neg_row4", w, rep(32'h40000000));

    // HALVE over col 31 and wrapped col 0
    wr(5'd31, 6'd0, MIX_IN, 1'b0);
    wr(5'd31, 6'd1, MIX_IN, 1'b0);
    wr(5'd31, 6'd2, MIX_IN, 1'b0);
    for (int r = 0; r < 4; r++)
      wr(5'd0, 6'(r), MIX_IN, 1'b0);
    cfg(1'b1, 6'd2, 6'd3);
    run_op(2'd3, 5'd31, n);
`ifdef QRD_UNIT_PU1_EN
    chk("halve_cyc", 256'(n), 256'd5);
    for (int r = 0; r < 3; r++) begin
      rd(5'd0, 6'(r), w, v);
      chk($sformatf("halve_c0r%0d", r), w, MIX_OUT);
    end
`else
    chk("halve_cyc", 256'(n), 256'd2);
    for (int r = 0; r < 3; r++) begin
      rd(5'd0, 6'(r), w, v);
      chk($sformatf("halve_c0r%0d", r), w, MIX_IN);
    end
`endif
    rd(5'd31, 6'd0, w, v);
    chk("halve_c31r0", w, MIX_OUT);
    rd(5'd31, 6'd1, w, v);
    chk("halve_c31r1", w, MIX_OUT);
    rd(5'd31, 6'd2, w, v);
    chk("halve_c31r2", w, MIX_IN);
    rd(5'd0, 6'd3, w, v);
    chk("halve_c0r3", w, MIX_IN);

    // NOP completes next cycle
    cfg(1'b0, 6'd4, 6'd0);
    run_op(2'd0, 5'd3, n);
    chk("nop_cyc", 256'(n), 256'd0);

    // write during RUN0 dropped
    w_a = rep(32'h11111111);
    wr(5'd10, 6'd2, w_a, 1'b0);
    cfg(1'b0, 6'd8, 6'd0);
    bus.io_op_valid    = 1'b1;
    bus.io_op_bits     = 2'd1;
    bus.io_read_column = 5'd9;
    tick();
    bus.io_op_valid = 1'b0;
    chk("busy_done_clr", 256'(bus.io_done), 256'd0);
    wr(5'd10, 6'd2, rep(32'h22222222), 1'b0);
    wait_done(n);
    chk("busy_cyc", 256'(n), 256'd7);
    rd(5'd10, 6'd2, w, v);
    chk("busy_wr_drop", w, w_a);

    // same-cycle write and read, then zero write
    drive_wr(5'd10, 6'd2, rep(32'h33333333), 1'b0);
    rd(5'd10, 6'd2, w, v);
    bus.io_write_req_valid = 1'b0;
    chk("rw_same_old", w, w_a);
    rd(5'd10, 6'd2, w, v);
    chk("rw_same_new", w, rep(32'h33333333));
    wr(5'd10, 6'd2, rep(32'hFFFFFFFF), 1'b1);
    rd(5'd10, 6'd2, w, v);
    chk("zero_wr", w, 256'd0);

    // reset mid-op
    wr(5'd20, 6'd0, rep(32'h3F800000), 1'b0);
`ifdef QRD_UNIT_PU1_EN
    cfg(1'b1, 6'd3, 6'd4);
`else
    cfg(1'b0, 6'd8, 6'd0);
`endif
    bus.io_op_valid    = 1'b1;
    bus.io_op_bits     = 2'd1;
    bus.io_read_column = 5'd20;
    tick();
    bus.io_op_valid = 1'b0;
    repeat (3) tick();
    bus.io_read_req = 1'b1;
    tick();
    bus.io_read_req = 1'b0;
    chk("pre_rst_valid", 256'(bus.io_read_output_valid), 256'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 256'(bus.io_read_output_valid), 256'd0);
    chk("mid_rst_done", 256'(bus.io_done), 256'd0);
    tick();
    rst_n = 1'b1;
    run_op(2'd1, 5'd20, n);
    chk("post_rst_accept", 256'(n), 256'd0);
    chk("post_rst_done", 256'(bus.io_done), 256'd1);
    rd(5'd20, 6'd0, w, v);
    chk("rst_partial_row", w, rep(32'hBF800000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
